text_cursor_writer: RTL and testbench

Terminal-style character writer sitting directly upstream of the VGA text-mode renderer's 50x30 character display memory (1500 cells, 6-bit glyph codes, cell address = row*50 + col). It accepts a stream of 6-bit codes over a valid/ready handshake, keeps a cursor inside the bordered interior (cols 1..48, rows 1..28), and issues single-cell writes into the display memory. It also implements newline, backspace, home, clear-screen and hardware scroll-up by read/copy through the memory's read port.

---
 rtl/text_cursor_writer.sv | 244 ++++++++++++++++++++++++
 tb/tb_text_cursor_writer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_cursor_writer.sv
// Terminal-style character writer feeding the 50x30 text display memory.
// Define TEXT_CURSOR_EN to draw the cursor glyph (56) after every operation.
module text_cursor_writer #(
    parameter int COLS = 50,
    parameter int ROWS = 30
) (
    input  logic        clk_20mhz,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [5:0]  char_code,
    output logic        char_ready,
    output logic        wr_en,
    output logic [10:0] wr_addr,
    output logic [5:0]  wr_data,
    output logic        rd_en,
    output logic [10:0] rd_addr,
    input  logic [5:0]  rd_data,
    output logic [4:0]  cursor_row,
    output logic [5:0]  cursor_col
);
    localparam logic [5:0]  LAST_COL     = 6'(COLS - 2);
    localparam logic [4:0]  LAST_ROW     = 5'(ROWS - 2);
    localparam logic [10:0] ROW_STRIDE   = 11'(COLS);
    localparam logic [5:0]  GLYPH_BLANK  = 6'd57;
    localparam logic [5:0]  GLYPH_CURSOR = 6'd56;

    typedef enum logic [2:0] {
        IDLE, PUT, ERASE, CURS, SCROLL_RD, SCROLL_WR, CLR_ROW, CLR_ALL
    } state_t;

    typedef enum logic [1:0] {OP_NEWLINE, OP_BACKSPACE, OP_HOME} op_t;

`ifdef TEXT_CURSOR_EN
    localparam state_t DONE = CURS;
`else
    localparam state_t DONE = IDLE;
`endif

    state_t      state, state_n;
    op_t         op, op_n;
    logic [4:0]  row_q, row_n, scan_row, scan_row_n;
    logic [5:0]  col_q, col_n, scan_col, scan_col_n;
    logic        wr_en_n, rd_en_n;
    logic [10:0] wr_addr_n, rd_addr_n;
    logic [5:0]  wr_data_q, wr_data_n;

    function automatic logic [10:0] cell_addr(input logic [4:0] r, input logic [5:0] c);
        return 11'(r) * ROW_STRIDE + 11'(c);
    endfunction

    assign char_ready = (state == IDLE) && !reset;
    assign cursor_row = row_q;
    assign cursor_col = col_q;
    // Read data arrives one cycle after rd_en, exactly in the SCROLL_WR cycle, so it is passed straight through.
    assign wr_data    = (state == SCROLL_WR) ? rd_data : wr_data_q;

    always_comb begin
        state_n    = state;
        op_n       = op;
        row_n      = row_q;
        col_n      = col_q;
        scan_row_n = scan_row;
        scan_col_n = scan_col;
        case (state)
            IDLE: begin
                if (char_valid) begin
                    if (char_code <= 6'd58) begin
                        state_n = PUT;
                    end else begin
                        case (char_code)
                            6'd60: begin
                                state_n = ERASE;
                                op_n    = OP_NEWLINE;
                            end
                            6'd61: begin
                                if (col_q != 6'd1) begin
                                    state_n = ERASE;
                                    op_n    = OP_BACKSPACE;
                                end
                            end
                            6'd62: begin
                                state_n    = CLR_ALL;
                                scan_row_n = 5'd1;
                                scan_col_n = 6'd1;
                            end
                            6'd63: begin
                                state_n = ERASE;
                                op_n    = OP_HOME;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            PUT: begin
                state_n = DONE;
                if (col_q == LAST_COL) begin
                    col_n = 6'd1;
                    if (row_q == LAST_ROW) begin
                        state_n    = SCROLL_RD;
                        scan_row_n = 5'd2;
                        scan_col_n = 6'd1;
                    end else begin
                        row_n = row_q + 5'd1;
                    end
                end else begin
                    col_n = col_q + 6'd1;
                end
            end
            ERASE: begin
                state_n = DONE;
                case (op)
                    OP_NEWLINE: begin
                        col_n = 6'd1;
                        if (row_q < LAST_ROW) begin
                            row_n = row_q + 5'd1;
                        end else begin
                            state_n    = SCROLL_RD;
                            scan_row_n = 5'd2;
                            scan_col_n = 6'd1;
                        end
                    end
                    OP_BACKSPACE: col_n = col_q - 6'd1;
                    default: begin
                        row_n = 5'd1;
                        col_n = 6'd1;
                    end
                endcase
            end
            SCROLL_RD: state_n = SCROLL_WR;
            SCROLL_WR: begin
                state_n = SCROLL_RD;
                if (scan_col == LAST_COL) begin
                    scan_col_n = 6'd1;
                    if (scan_row == LAST_ROW) begin
                        state_n = CLR_ROW;
                    end else begin
                        scan_row_n = scan_row + 5'd1;
                    end
                end else begin
                    scan_col_n = scan_col + 6'd1;
                end
            end
            CLR_ROW: begin
                if (scan_col == LAST_COL) begin
                    state_n = DONE;
                    row_n   = LAST_ROW;
                    col_n   = 6'd1;
                end else begin
                    scan_col_n = scan_col + 6'd1;
                end
            end
            CLR_ALL: begin
                if (scan_col == LAST_COL) begin
                    scan_col_n = 6'd1;
                    if (scan_row == LAST_ROW) begin
                        state_n = DONE;
                        row_n   = 5'd1;
                        col_n   = 6'd1;
                    end else begin
                        scan_row_n = scan_row + 5'd1;
                    end
                end else begin
                    scan_col_n = scan_col + 6'd1;
                end
            end
            CURS:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Memory strobes are registered, so they are derived from the state being entered.
    always_comb begin
        wr_en_n   = 1'b0;
        wr_addr_n = 11'd0;
        wr_data_n = 6'd0;
        rd_en_n   = 1'b0;
        rd_addr_n = 11'd0;
        case (state_n)
            PUT: begin
                wr_en_n   = 1'b1;
                wr_addr_n = cell_addr(row_q, col_q);
                wr_data_n = char_code;
            end
            ERASE: begin
                wr_en_n   = 1'b1;
                wr_addr_n = cell_addr(row_q, col_q);
                wr_data_n = GLYPH_BLANK;
            end
            CURS: begin
                wr_en_n   = 1'b1;
                wr_addr_n = cell_addr(row_n, col_n);
                wr_data_n = GLYPH_CURSOR;
            end
            SCROLL_RD: begin
                rd_en_n   = 1'b1;
                rd_addr_n = cell_addr(scan_row_n, scan_col_n);
            end
            SCROLL_WR: begin
                wr_en_n   = 1'b1;
                wr_addr_n = cell_addr(scan_row_n, scan_col_n) - ROW_STRIDE;
            end
            CLR_ROW: begin
                wr_en_n   = 1'b1;
                wr_addr_n = cell_addr(LAST_ROW, scan_col_n);
                wr_data_n = GLYPH_BLANK;
            end
            CLR_ALL: begin
                wr_en_n   = 1'b1;
                wr_addr_n = cell_addr(scan_row_n, scan_col_n);
                wr_data_n = GLYPH_BLANK;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_20mhz) begin
        if (reset) begin
            state     <= IDLE;
            op        <= OP_NEWLINE;
            row_q     <= 5'd1;
            col_q     <= 6'd1;
            scan_row  <= 5'd1;
            scan_col  <= 6'd1;
            wr_en     <= 1'b0;
            wr_addr   <= 11'd0;
            wr_data_q <= 6'd0;
            rd_en     <= 1'b0;
            rd_addr   <= 11'd0;
        end else begin
            state     <= state_n;
            op        <= op_n;
            row_q     <= row_n;
            col_q     <= col_n;
            scan_row  <= scan_row_n;
            scan_col  <= scan_col_n;
            wr_en     <= wr_en_n;
            wr_addr   <= wr_addr_n;
            wr_data_q <= wr_data_n;
            rd_en     <= rd_en_n;
            rd_addr   <= rd_addr_n;
        end
    end
endmodule

// File: tb/tb_text_cursor_writer.sv
// Scoreboard bench for text_cursor_writer with a behavioural display memory.
// Compile with the same TEXT_CURSOR_EN setting as the design.
module tb_text_cursor_writer;
    logic        clk_20mhz;
    logic        reset;
    logic        char_valid;
    logic [5:0]  char_code;
    logic        char_ready;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [5:0]  wr_data;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic [5:0]  rd_data;
    logic [4:0]  cursor_row;
    logic [5:0]  cursor_col;

    int checks = 0;
    int errors = 0;

    logic [16:0] wr_q[$];
    logic [10:0] rd_q[$];
    logic [5:0]  mem   [0:1499];
    logic [5:0]  model [0:1499];
    logic        preload;
    int          m_row, m_col, exp_busy;

    text_cursor_writer dut (
        .clk_20mhz (clk_20mhz),
        .reset     (reset),
        .char_valid(char_valid),
        .char_code (char_code),
        .char_ready(char_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .cursor_row(cursor_row),
        .cursor_col(cursor_col)
    );

    initial begin
        clk_20mhz = 1'b0;
        forever #5 clk_20mhz = ~clk_20mhz;
    end

    // Display memory: synchronous write, one-cycle registered read.
    always @(posedge clk_20mhz) begin
        if (preload) begin
            for (int i = 0; i < 1500; i++) mem[i] <= 6'(i % 59);
            rd_data <= 6'd0;
        end else begin
            if (wr_en && wr_addr < 11'd1500) mem[wr_addr] <= wr_data;
            if (rd_en && rd_addr < 11'd1500) rd_data <= mem[rd_addr];
        end
    end

    function automatic logic [10:0] addr_of(input int r, input int c);
        return 11'(r * 50 + c);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Every memory access is popped from the scoreboard in issue order.
    always @(negedge clk_20mhz) begin
        if (wr_en || rd_en) check("rd_wr_exclusive", 32'(wr_en && rd_en), 32'd0);
        if (wr_en) begin
            check("write_interior", 32'((wr_addr / 50) >= 1 && (wr_addr / 50) <= 28 &&
                                        (wr_addr % 50) >= 1 && (wr_addr % 50) <= 48), 32'd1);
            check("write_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) check("write_addr_data", 32'({wr_addr, wr_data}), 32'(wr_q.pop_front()));
        end
        if (rd_en) begin
            check("read_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) check("read_addr", 32'(rd_addr), 32'(rd_q.pop_front()));
        end
    end

    task automatic push_wr(input logic [10:0] a, input logic [5:0] d);
        wr_q.push_back({a, d});
        model[a] = d;
        exp_busy++;
    endtask

    task automatic expect_scroll();
        for (int r = 2; r <= 28; r++)
            for (int c = 1; c <= 48; c++) begin
                rd_q.push_back(addr_of(r, c));
                exp_busy++;
                push_wr(addr_of(r - 1, c), model[addr_of(r, c)]);
            end
        for (int c = 1; c <= 48; c++) push_wr(addr_of(28, c), 6'd57);
        m_row = 28;
        m_col = 1;
    endtask

    // Each busy cycle carries exactly one memory access, so busy length equals accesses pushed.
    task automatic expect_char(input logic [5:0] code);
        logic acted;
        acted    = 1'b1;
        exp_busy = 0;
        if (code <= 6'd58) begin
            push_wr(addr_of(m_row, m_col), code);
            if (m_col == 48) begin
                m_col = 1;
                if (m_row == 28) expect_scroll();
                else m_row++;
            end else m_col++;
        end else if (code == 6'd60) begin
            push_wr(addr_of(m_row, m_col), 6'd57);
            m_col = 1;
            if (m_row < 28) m_row++;
            else expect_scroll();
        end else if (code == 6'd61) begin
            if (m_col == 1) acted = 1'b0;
            else begin
                push_wr(addr_of(m_row, m_col), 6'd57);
                m_col--;
            end
        end else if (code == 6'd62) begin
            for (int r = 1; r <= 28; r++)
                for (int c = 1; c <= 48; c++) push_wr(addr_of(r, c), 6'd57);
            m_row = 1;
            m_col = 1;
        end else if (code == 6'd63) begin
            push_wr(addr_of(m_row, m_col), 6'd57);
            m_row = 1;
            m_col = 1;
        end else acted = 1'b0;
`ifndef TEXT_CURSOR_EN
        acted = 1'b0;
`endif
        if (acted) push_wr(addr_of(m_row, m_col), 6'd56);
    endtask

    task automatic send(input logic [5:0] code);
        char_valid = 1'b1;
        char_code  = code;
        for (int n = 0; ; n++) begin
            @(negedge clk_20mhz);
            if (char_ready === 1'b1) break;
            if (n > 4000) begin
                check("accept_timeout", 32'(n), 32'd0);
                break;
            end
        end
        @(posedge clk_20mhz);
        #2 char_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int busy;
        busy = 0;
        for (int n = 0; ; n++) begin
            @(negedge clk_20mhz);
            if (char_ready === 1'b1) break;
            busy++;
            if (n > 6000) begin
                check({tag, "_idle_timeout"}, 32'(n), 32'd0);
                break;
            end
        end
        check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
        check({tag, "_pending"}, 32'(wr_q.size() + rd_q.size()), 32'd0);
        check({tag, "_row"}, 32'(cursor_row), 32'(m_row));
        check({tag, "_col"}, 32'(cursor_col), 32'(m_col));
        @(posedge clk_20mhz);
        #2;
    endtask

    task automatic applyStimulus(input logic [5:0] code, input string tag);
        expect_char(code);
        send(code);
        wait_idle(tag);
    endtask

    function automatic int cells_not(input int r, input int c_lo, input int c_hi, input logic [5:0] v);
        int cnt;
        cnt = 0;
        for (int c = c_lo; c <= c_hi; c++) if (mem[addr_of(r, c)] !== v) cnt++;
        return cnt;
    endfunction

    function automatic int screen_diff();
        int cnt;
        cnt = 0;
        for (int i = 0; i < 1500; i++) if (mem[i] !== model[i]) cnt++;
        return cnt;
    endfunction

    initial begin
        reset      = 1'b1;
        preload    = 1'b1;
        char_valid = 1'b0;
        char_code  = 6'd0;
        m_row      = 1;
        m_col      = 1;
        exp_busy   = 0;
        for (int i = 0; i < 1500; i++) model[i] = 6'(i % 59);
        @(posedge clk_20mhz);
        #2 preload = 1'b0;
        @(negedge clk_20mhz);
        check("reset_ready", 32'(char_ready), 32'd0);
        check("reset_wr_en", 32'(wr_en), 32'd0);
        check("reset_wr_addr", 32'(wr_addr), 32'd0);
        check("reset_wr_data", 32'(wr_data), 32'd0);
        check("reset_rd_en", 32'(rd_en), 32'd0);
        check("reset_rd_addr", 32'(rd_addr), 32'd0);
        check("reset_row", 32'(cursor_row), 32'd1);
        check("reset_col", 32'(cursor_col), 32'd1);
        @(posedge clk_20mhz);
        #2 reset = 1'b0;
        @(negedge clk_20mhz);
        check("ready_after_reset", 32'(char_ready), 32'd1);
        @(posedge clk_20mhz);
        #2;

        applyStimulus(6'd0, "glyph_a");
        applyStimulus(6'd63, "home");
        applyStimulus(6'd61, "bs_col1");
        applyStimulus(6'd1, "glyph_b");
        applyStimulus(6'd2, "glyph_c");
        applyStimulus(6'd61, "bs_col3");
        applyStimulus(6'd59, "ignored");
        applyStimulus(6'd63, "home2");
        for (int i = 0; i < 48; i++) applyStimulus(6'(i), "row_fill");
        check("row1_last_glyph", 32'(mem[98]), 32'd47);

        for (int i = 0; i < 26; i++) applyStimulus(6'd60, "newline");
        for (int i = 0; i < 47; i++) applyStimulus(6'd7, "marker");
        applyStimulus(6'd60, "nl_scroll");
        check("row27_marker", 32'(cells_not(27, 1, 47, 6'd7)), 32'd0);
        check("row27_col48_blank", 32'(mem[addr_of(27, 48)]), 32'd57);
        check("screen_after_scroll", 32'(screen_diff()), 32'd0);

        for (int i = 0; i < 48; i++) applyStimulus(6'(i + 10), "wrap_scroll");
        check("screen_after_wrap", 32'(screen_diff()), 32'd0);

        applyStimulus(6'd62, "clear");
        check("screen_after_clear", 32'(screen_diff()), 32'd0);

        expect_char(6'd62);
        send(6'd62);
        repeat (100) @(posedge clk_20mhz);
        #2 reset = 1'b1;
        @(posedge clk_20mhz);
        #2;
        wr_q.delete();
        rd_q.delete();
        @(negedge clk_20mhz);
        check("midreset_wr_en", 32'(wr_en), 32'd0);
        check("midreset_ready", 32'(char_ready), 32'd0);
        check("midreset_row", 32'(cursor_row), 32'd1);
        check("midreset_col", 32'(cursor_col), 32'd1);
        @(posedge clk_20mhz);
        #2 reset = 1'b0;
        @(negedge clk_20mhz);
        check("midreset_ready_after", 32'(char_ready), 32'd1);
        repeat (5) @(posedge clk_20mhz);
        #2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
